// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// RS-232 UART transmitter. Turns one parallel word per request into an
// asynchronous serial frame: start bit (0), data bits LSB first, an optional
// parity bit, then one or two stop bits (1). The baud-tick counter, bit
// counter, shift register and control FSM are all in this module.
//
// Parameters
//   BAUD_DIV   clock cycles per bit (>= 2)
//   DATA_BITS  data bits per frame (5..8)
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  stop bits per frame (1 or 2)
//
// Ports
//   clk_i    system clock, rising edge
//   rst_i    synchronous active-high reset
//   data_i   word to send, sampled only in the accept cycle
//   start_i  transmit request, honoured only while rdy_o = 1
//   tx_o     registered serial line, idles high
//   rdy_o    idle and able to accept start_i
//   busy_o   frame on the line (always ~rdy_o)
//   eot_o    single-cycle pulse on the cycle the FSM re-enters IDLE
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int unsigned BAUD_DIV  = 5208,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 start_i,
  output logic                 tx_o,
  output logic                 rdy_o,
  output logic                 busy_o,
  output logic                 eot_o
);

  // Reject illegal configurations while elaborating.
  generate
    if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
        PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
      $error("uart_tx: illegal parameter value");
    end
  endgenerate

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY_BIT,
    STOP
  } state_t;

  state_t               state;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;

  logic baud_wrap;
  assign baud_wrap = (baud_cnt == BAUD_LAST);

  // Single control process. tx_o always carries the value of the bit that
  // the current state is sending, so each transition loads the first value
  // of the next bit at the same edge the state changes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tx_o      <= 1'b1;
      rdy_o     <= 1'b1;
      busy_o    <= 1'b0;
      eot_o     <= 1'b0;
    end else begin
      eot_o <= 1'b0;
      if (state != IDLE) begin
        baud_cnt <= baud_wrap ? '0 : baud_cnt + CW'(1);
      end

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (start_i) begin
            shift_reg <= data_i;
            // Odd mode inverts the XOR so that data plus parity has odd weight.
            par_bit   <= (PARITY == 2) ? ~(^data_i) : (^data_i);
            state     <= START;
            tx_o      <= 1'b0;
            rdy_o     <= 1'b0;
            busy_o    <= 1'b1;
          end
        end

        START: begin
          if (baud_wrap) begin
            state <= DATA;
            tx_o  <= shift_reg[0];
          end
        end

        DATA: begin
          if (baud_wrap) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state <= PARITY_BIT;
                tx_o  <= par_bit;
              end else begin
                state <= STOP;
                tx_o  <= 1'b1;
              end
            end else begin
              // Present the next bit now; shift_reg[0] stays the bit on the line.
              bit_cnt   <= bit_cnt + 3'd1;
              shift_reg <= shift_reg >> 1;
              tx_o      <= shift_reg[1];
            end
          end
        end

        PARITY_BIT: begin
          if (baud_wrap) begin
            state <= STOP;
            tx_o  <= 1'b1;
          end
        end

        STOP: begin
          if (baud_wrap) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= IDLE;
              rdy_o   <= 1'b1;
              busy_o  <= 1'b0;
              eot_o   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
          tx_o  <= 1'b1;
          rdy_o <= 1'b1;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Bench for uart_tx. Three instances share one stimulus stream:
//   u_8n1 : 8 data bits, no parity, 1 stop bit
//   u_8e1 : 8 data bits, even parity, 1 stop bit
//   u_8o2 : 8 data bits, odd parity, 2 stop bits
// A frame-level model predicts every output of every instance each cycle;
// directed sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int B = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;

  logic tx[3];
  logic rdy[3];
  logic busy[3];
  logic eot[3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  uart_tx #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .start_i(start),
    .tx_o(tx[0]), .rdy_o(rdy[0]), .busy_o(busy[0]), .eot_o(eot[0]));

  uart_tx #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .start_i(start),
    .tx_o(tx[1]), .rdy_o(rdy[1]), .busy_o(busy[1]), .eot_o(eot[1]));

  uart_tx #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_8o2 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .start_i(start),
    .tx_o(tx[2]), .rdy_o(rdy[2]), .busy_o(busy[2]), .eot_o(eot[2]));

  // Configuration of each instance as the model sees it.
  function automatic int parOf(input int c);
    return (c == 0) ? 0 : ((c == 1) ? 1 : 2);
  endfunction

  function automatic int stopOf(input int c);
    return (c == 2) ? 2 : 1;
  endfunction

  function automatic int frameBits(input int c);
    return 1 + 8 + ((parOf(c) != 0) ? 1 : 0) + stopOf(c);
  endfunction

  // Value of frame bit idx (0 = start bit) for word d on instance c.
  function automatic logic frameBit(input int c, input logic [7:0] d, input int idx);
    int ones;
    ones = $countones(d);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && parOf(c) == 1) return (ones % 2) == 1;
    if (idx == 9 && parOf(c) == 2) return (ones % 2) == 0;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input int c, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d] cyc=%0d actual=%b expected=%b", name, c, cyc, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; they are sampled at the
  // next rising edge.
  task automatic applyStimulus(input logic r, input logic s, input logic [7:0] d);
    @(negedge clk);
    rst   = r;
    start = s;
    data  = d;
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      ok = rdy[0] && rdy[1] && rdy[2];
    end
    if (!ok) checkCount("idle_timeout", 0, 1);
  endtask

  // Frame-level model and the per-cycle compare process.
  logic       m_valid = 1'b0;
  logic       m_act[3];
  int         m_t0[3];
  logic [7:0] m_data[3];
  logic       e_tx[3], e_rdy[3], e_busy[3], e_eot[3];

  initial begin : compare
    for (int c = 0; c < 3; c++) m_act[c] = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) m_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
        e_eot[c] = 1'b0;
        if (rst) begin
          m_act[c] = 1'b0;
        end else if (m_act[c] && (cyc - m_t0[c]) == frameBits(c) * B) begin
          m_act[c] = 1'b0;
          e_eot[c] = 1'b1;
        end else if (!m_act[c] && start) begin
          m_act[c]  = 1'b1;
          m_t0[c]   = cyc;
          m_data[c] = data;
        end
        if (m_act[c]) begin
          e_tx[c]   = frameBit(c, m_data[c], (cyc - m_t0[c]) / B);
          e_rdy[c]  = 1'b0;
          e_busy[c] = 1'b1;
        end else begin
          e_tx[c]   = 1'b1;
          e_rdy[c]  = 1'b1;
          e_busy[c] = 1'b0;
        end
      end
      @(negedge clk);
      if (m_valid) begin
        for (int c = 0; c < 3; c++) begin
          checkOutput("tx", c, tx[c], e_tx[c]);
          checkOutput("rdy", c, rdy[c], e_rdy[c]);
          checkOutput("busy", c, busy[c], e_busy[c]);
          checkOutput("eot", c, eot[c], e_eot[c]);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int busyCnt, eotCnt, e;
    logic [9:0] frame55;

    // Pin the model with hand-derived frames.
    frame55 = 10'b1_01010101_0;
    for (int i = 0; i < 10; i++) checkOutput("model_55", 0, frameBit(0, 8'h55, i), frame55[i]);
    checkOutput("model_a5_even", 1, frameBit(1, 8'hA5, 9), 1'b0);
    checkOutput("model_a5_odd", 2, frameBit(2, 8'hA5, 9), 1'b1);
    checkCount("model_len_8o2", frameBits(2), 12);

    // Reset for 3 cycles, then 20 idle cycles.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 3; c++) begin
        checkOutput("idle_tx", c, tx[c], 1'b1);
        checkOutput("idle_eot", c, eot[c], 1'b0);
      end
    end

    // 8N1 0x55: bit pattern, eot 40 cycles after accept, busy for 40 cycles.
    waitIdle();
    applyStimulus(1'b0, 1'b1, 8'h55);
    busyCnt = 0;
    eotCnt = 0;
    for (int i = 0; i <= 40; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      if (i < 40) checkOutput("n1_bit", 0, tx[0], frame55[i / B]);
      if (busy[0]) busyCnt++;
      if (eot[0] && i < 40) eotCnt++;
    end
    checkOutput("n1_eot_at_40", 0, eot[0], 1'b1);
    checkCount("n1_busy_cycles", busyCnt, 40);
    checkCount("n1_early_eot", eotCnt, 0);

    // Parity on 0xA5; odd instance has two stop bits.
    waitIdle();
    applyStimulus(1'b0, 1'b1, 8'hA5);
    busyCnt = 0;
    for (int i = 0; i <= 48; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      if (i == 37) begin
        checkOutput("par_even", 1, tx[1], 1'b0);
        checkOutput("par_odd", 2, tx[2], 1'b1);
      end
      if (i >= 40 && i < 48 && tx[2]) busyCnt++;
      if (i == 44) checkOutput("e1_eot_at_44", 1, eot[1], 1'b1);
    end
    checkCount("o2_stop_high", busyCnt, 8);
    checkOutput("o2_eot_at_48", 2, eot[2], 1'b1);

    // Back-to-back with start held high: 0x01 then 0x80.
    waitIdle();
    applyStimulus(1'b0, 1'b1, 8'h01);
    e = -1;
    for (int i = 0; i < 120; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h80);
      if (e >= 0) begin
        checkOutput("b2b_restart", 0, tx[0], 1'b0);
        break;
      end
      if (eot[0]) begin
        e = i;
        checkOutput("b2b_gap", 0, tx[0], 1'b1);
      end
    end
    checkCount("b2b_eot_at", e, 40);
    applyStimulus(1'b0, 1'b0, 8'h00);

    // Ignored request mid-frame.
    waitIdle();
    applyStimulus(1'b0, 1'b1, 8'h00);
    eotCnt = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b0, (i == 10), (i == 10) ? 8'hFF : 8'h00);
      if (eot[0]) eotCnt++;
    end
    checkCount("ign_eot_count", eotCnt, 1);
    checkOutput("ign_no_extra", 0, rdy[0], 1'b1);

    // Reset during data bit 3, then a fresh 0x3C frame.
    waitIdle();
    applyStimulus(1'b0, 1'b1, 8'hC3);
    for (int i = 0; i < 18; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("rst_mid_tx", 0, tx[0], 1'b1);
    checkOutput("rst_mid_rdy", 0, rdy[0], 1'b1);
    checkOutput("rst_mid_busy", 0, busy[0], 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i <= 40; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("rst_new_eot", 0, eot[0], 1'b1);

    // Randomized traffic, including rare resets and reset+start collisions.
    for (int i = 0; i < 2500; i++) begin
      applyStimulus(($urandom % 400) == 0, ($urandom % 6) == 0, 8'($urandom));
    end
    waitIdle();
    applyStimulus(1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
